rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL provide parameter N, default 4, number of requesters sharing the mux output (2..8).
REQ-002 SHALL provide parameter W, default 8, data width per requester.
REQ-003 SHALL provide parameter MAX_HOLD, default 4, maximum consecutive grant cycles per requester (1..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  N  request vector; bit i = requester i wants the output channel.
REQ-007 in_data  input  N*W  packed data; requester i occupies bits [i*W +: W].
REQ-008 gnt  output  N  one-hot grant vector, registered.
REQ-009 sel  output  clog2(N)  registered mux select = index of granted requester.
REQ-010 out_valid  output  1  high in every cycle a grant is active.
REQ-011 out_data  output  W  in_data slice selected by sel when out_valid = 1, else all zeros.

Function
REQ-012 SHALL implement two states: IDLE (no grant) and GRANT (exactly one gnt bit high).
REQ-013 SHALL keep a round-robin pointer ptr (clog2(N) bits): the highest-priority index for the next arbitration.
REQ-014 Arbitration: winner = first i with req[i] = 1, scanning ptr, ptr+1, ... mod N; wrap-around from N-1 to 0.
REQ-015 IDLE: if req != 0 at an edge -> GRANT with winner; gnt/sel/out_valid update on that edge (1-cycle latency req -> gnt); else stay IDLE.
REQ-016 GRANT: hold_cnt counts cycles granted, cleared on each new grant, incremented each GRANT cycle that is not a release.
REQ-017 Release condition at an edge: req[sel] = 0 OR hold_cnt = MAX_HOLD-1.
REQ-018 On release: ptr <= (sel+1) mod N; arbitrate with that new ptr over the current req in the same edge; if winner exists -> grant it, no idle bubble; else -> IDLE.
REQ-019 Released requester still requesting SHALL be re-granted only if no other requester is requesting (lowest priority after release).
REQ-020 No release while req[sel] = 1 and hold_cnt < MAX_HOLD-1: gnt/sel unchanged, regardless of other requests.
REQ-021 MAX_HOLD = 1: release every cycle; continuous all-ones req yields grant rotation 0,1,2,...,N-1,0.
REQ-022 gnt SHALL never have more than one bit set; gnt = 0 exactly when out_valid = 0.
REQ-023 out_data SHALL be combinational from registered sel and current in_data (same-cycle data pass-through).
REQ-024 req bits at index >= N do not exist; ptr and sel SHALL never exceed N-1.

Reset
REQ-025 rst = 1 at an edge: state <= IDLE, gnt <= 0, sel <= 0, ptr <= 0, hold_cnt <= 0; out_valid = 0, out_data = 0 from that edge.
REQ-026 rst mid-GRANT SHALL abort the grant with no extra cycle; first grant after rst deasserts follows REQ-015 with ptr = 0.
REQ-027 rst SHALL dominate all req activity in the same cycle.

Verification
REQ-028 Reset: rst high 2 cycles with req = 4'b1111 -> gnt = 0, out_valid = 0, out_data = 0 throughout; after release, first grant gnt = 4'b0001 one cycle later.
REQ-029 Single requester: req = 4'b0100 held 6 cycles, in_data[2] = 8'hA5 -> gnt = 4'b0100 with out_data = 8'hA5; at hold_cnt = 3 re-granted to 2 (no competitor), out_valid stays 1.
REQ-030 Fairness: req = 4'b1111 constant, MAX_HOLD = 4 -> requesters 0,1,2,3,0 each granted exactly 4 consecutive cycles, no idle gap.
REQ-031 Early drop: req = 4'b0011, requester 0 granted, drops req[0] after 2 cycles -> next edge gnt = 4'b0010, hold_cnt restarts at 0.
REQ-032 Wrap-around: requester 3 granted, req = 4'b1001 at release -> next gnt = 4'b0001 (ptr wraps to 0).
REQ-033 Reset mid-grant: rst pulsed while gnt = 4'b0100, hold_cnt = 2 -> gnt = 0 next edge; after rst with req = 4'b0100 -> gnt = 4'b0100, full MAX_HOLD window.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a data mux. One requester owns the output
// channel at a time. It keeps the channel until it drops its request or has
// held it for MAX_HOLD cycles, and then passes it on without an idle bubble.
//
// state | meaning
// IDLE  | no grant active, outputs quiet
// GRANT | exactly one requester owns the mux output
module rr_mux_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4,
  localparam int SW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     gnt,
  output logic [SW-1:0]    sel,
  output logic             out_valid,
  output logic [W-1:0]     out_data
);

  localparam logic [0:0] STATE_IDLE  = 1'b0;
  localparam logic [0:0] STATE_GRANT = 1'b1;
  localparam logic [3:0] HOLD_LAST   = 4'(MAX_HOLD - 1);

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [3:0]    hold_q, hold_d;

  logic [SW-1:0] next_ptr;
  logic [SW-1:0] arb_ptr;
  logic [SW-1:0] win;
  logic          win_found;
  logic          release_now;

  // Pointer just past the current owner, wrapping at N-1 (N need not be a power of two)
  always_comb begin
    if (int'(sel_q) == N - 1) next_ptr = '0;
    else                      next_ptr = sel_q + SW'(1);
  end

  assign release_now = (state_q == STATE_GRANT) &&
                       (!req[sel_q] || (hold_q == HOLD_LAST));

  // On a release the new pointer is used in the same edge, so the owner
  // being released drops to lowest priority immediately
  assign arb_ptr = (state_q == STATE_GRANT) ? next_ptr : ptr_q;

  // Scan requests starting at arb_ptr; the first requester found wins
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win       = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(arb_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win       = SW'(idx);
      end
    end
  end

  // Next-state decisions for grant ownership, hold counter and pointer
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if (state_q == STATE_IDLE) begin
      if (win_found) begin
        state_d = STATE_GRANT;
        sel_d   = win;
        gnt_d   = {{(N-1){1'b0}}, 1'b1} << win;
        hold_d  = '0;
      end
    end else if (release_now) begin
      ptr_d = next_ptr;
      if (win_found) begin
        sel_d  = win;
        gnt_d  = {{(N-1){1'b0}}, 1'b1} << win;
        hold_d = '0;
      end else begin
        state_d = STATE_IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    end else begin
      hold_d = hold_q + 4'd1;
    end
  end

  // State registers; reset overrides any request activity in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STATE_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign out_valid = (state_q == STATE_GRANT);
  // Data passes straight through from the selected input in the same cycle
  assign out_data  = out_valid ? in_data[int'(sel_q)*W +: W] : '0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios with literal expected grants,
// then randomized traffic compared every cycle against an owner/pointer model.
module tb_rr_mux_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   gnt;
  logic [1:0]     sel;
  logic           out_valid;
  logic [W-1:0]   out_data;

  int checks = 0;
  int errors = 0;

  // model: current owner (-1 = none), priority pointer, cycles held so far
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit chk_en  = 1'b0;

  rr_mux_arbiter #(.N(N), .W(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .in_data(in_data),
    .gnt(gnt), .sel(sel), .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic int pick(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int o);
    logic [N-1:0] v;
    v = '0;
    if (o >= 0) v[o] = 1'b1;
    return v;
  endfunction

  task automatic step_model();
    int w;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_held = 0;
    end else if (m_owner < 0) begin
      w = pick(m_ptr, req);
      if (w >= 0) begin m_owner = w; m_held = 1; end
    end else if (!req[m_owner] || m_held == MH) begin
      m_ptr   = (m_owner + 1) % N;
      w       = pick(m_ptr, req);
      m_owner = w;
      m_held  = (w >= 0) ? 1 : 0;
    end else begin
      m_held = m_held + 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs for one edge; exp >= 0 pins the grant seen after that edge
  task automatic cyc(input logic r, input logic [N-1:0] rq, input int exp, input string name);
    rst = r;
    req = rq;
    @(posedge clk);
    step_model();
    #2;
    chk_en = 1'b1;
    if (exp >= 0) begin
      check({name, " dut gnt"}, 32'(gnt), 32'(exp));
      check({name, " model gnt"}, 32'(onehot(m_owner)), 32'(exp));
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("gnt", 32'(gnt), 32'(onehot(m_owner)));
        check("out_valid", 32'(out_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
        check("out_data", 32'(out_data),
              (m_owner >= 0) ? 32'(in_data[m_owner*W +: W]) : 32'd0);
        if (m_owner >= 0) check("sel", 32'(sel), 32'(m_owner));
        check("gnt onehot0", 32'($onehot0(gnt)), 32'd1);
      end
    end
  end

  initial begin
    logic [N-1:0] cur_req;
    rst     = 1'b1;
    req     = '0;
    in_data = {$urandom};

    // reset with all requesting, then rotation with full hold windows
    cyc(1'b1, 4'b1111, 0, "rst1");
    cyc(1'b1, 4'b1111, 0, "rst2");
    check("rst sel", 32'(sel), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    cyc(1'b0, 4'b1111, 1, "first grant");
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1111, 1, "fair r0");
    for (int r = 1; r < N; r++)
      for (int i = 0; i < MH; i++) cyc(1'b0, 4'b1111, 1 << r, "fair rot");
    cyc(1'b0, 4'b1111, 1, "fair wrap");

    // single requester re-granted after its window, data passes through
    cyc(1'b1, 4'b0000, 0, "rst single");
    in_data[2*W +: W] = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 4'b0100, 4, "single");
      check("single out_data", 32'(out_data), 32'hA5);
    end

    // early drop by requester 0; requester 1 then gets a full window
    cyc(1'b1, 4'b0000, 0, "rst drop");
    cyc(1'b0, 4'b0011, 1, "drop g0");
    cyc(1'b0, 4'b0011, 1, "drop g0b");
    cyc(1'b0, 4'b0010, 2, "drop g1");
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0011, 2, "drop hold");
    cyc(1'b0, 4'b0011, 1, "drop back0");

    // pointer wraps from 3 to 0
    cyc(1'b1, 4'b0000, 0, "rst wrap");
    cyc(1'b0, 4'b1000, 8, "wrap g3");
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1001, 8, "wrap hold");
    cyc(1'b0, 4'b1001, 1, "wrap g0");

    // reset in the middle of a grant
    cyc(1'b1, 4'b0000, 0, "rst mid");
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0100, 4, "mid pre");
    cyc(1'b1, 4'b0100, 0, "mid rst");
    for (int i = 0; i < MH; i++) cyc(1'b0, 4'b0100, 4, "mid post");
    cyc(1'b0, 4'b0100, 4, "mid regrant");

    // randomized traffic with sticky request patterns and rare resets
    cur_req = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      in_data = {$urandom};
      if ($urandom_range(0, 3) == 0) cur_req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) cur_req = 4'b1111;
      cyc(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, cur_req, -1, "rand");
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
